max7219_framebuffer: RTL and testbench
======================================

MAX7219_FRAMEBUFFER -- requirements
Module: max7219_framebuffer

Interface
REQ-001 The block SHALL have parameter DISP_ROWS, default 5, giving the number of 8x8 matrix rows in the chain.
REQ-002 The block SHALL have parameter DISP_COLUMNS, default 4, giving the number of 8x8 matrix columns in the chain.
REQ-003 The block SHALL have parameter DOUBLE_BUFFER, default 1: 1 = separate back/front buffers, 0 = single buffer.
REQ-004 Derived values SHALL be WIDTH=DISP_COLUMNS*8, HEIGHT=DISP_ROWS*8, XW=$clog2(WIDTH), YW=$clog2(HEIGHT).
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 i_Clk  in  1  system clock.
REQ-007 i_Rst  in  1  synchronous active-high reset.
REQ-008 i_Pix_Valid  in  1  pixel command valid.
REQ-009 o_Pix_Ready  out  1  pixel command accepted when high with i_Pix_Valid.
REQ-010 i_Pix_X  in  XW  pixel column.
REQ-011 i_Pix_Y  in  YW  pixel row.
REQ-012 i_Pix_Op  in  2  pixel operation: 00 clear, 01 set, 10 toggle, 11 no-op.
REQ-013 i_Fill_Valid  in  1  request to fill the whole draw buffer.
REQ-014 i_Fill_Value  in  1  fill bit value.
REQ-015 i_Swap_Req  in  1  level request to present the draw buffer.
REQ-016 i_Frame_Done  in  1  one-cycle pulse from the SPI driver at the end of a full refresh.
REQ-017 o_Swap_Ack  out  1  one-cycle pulse when the swap takes effect.
REQ-018 o_Busy  out  1  high whenever the state is not IDLE.
REQ-019 o_Err_Range  out  1  one-cycle pulse when an out-of-range pixel command is dropped.
REQ-020 o_MAX7219_DataStream  out  [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0]  display stream for the driver.

Function
REQ-021 Storage SHALL be bit arrays [0:HEIGHT-1][WIDTH-1:0]: two arrays (draw and front) if DOUBLE_BUFFER=1, one array if DOUBLE_BUFFER=0 (draw and front are the same array).
REQ-022 Pixel (x,y) SHALL map to: stream digit d = y mod 8, matrix row dr = y/8, matrix column dc = x/8, data bit (x mod 8), with bit 7 sent first.
REQ-023 Each stream element [d][dr][dc] SHALL be {8'(d+1), data byte}, and SHALL be registered from the front buffer with 1-cycle latency.
REQ-024 The FSM SHALL have states IDLE, FILL, SWAP_WAIT and COPY.
REQ-025 o_Pix_Ready SHALL equal (state==IDLE) && !i_Fill_Valid && !i_Swap_Req && !i_Rst.
REQ-026 An accepted pixel command SHALL update the draw buffer at the accepting clock edge.
REQ-027 A pixel command with x>=WIDTH or y>=HEIGHT SHALL be accepted, dropped, and pulse o_Err_Range in the next cycle.
REQ-028 IDLE priority SHALL be Fill > Swap > Pixel.
REQ-029 i_Fill_Valid in IDLE SHALL capture i_Fill_Value and enter FILL, which writes one draw-buffer row per cycle, rows 0..HEIGHT-1 (HEIGHT cycles), then returns to IDLE.
REQ-030 With DOUBLE_BUFFER=1, i_Swap_Req in IDLE SHALL enter SWAP_WAIT; an i_Frame_Done pulse in the same cycle as entry SHALL be ignored.
REQ-031 In SWAP_WAIT, the first i_Frame_Done SHALL toggle the front-select bit at that edge, pulse o_Swap_Ack in the next cycle, and enter COPY.
REQ-032 COPY SHALL copy the new front buffer into the new draw buffer one row per cycle (HEIGHT cycles), then return to IDLE.
REQ-033 With DOUBLE_BUFFER=0, i_Swap_Req in IDLE SHALL pulse o_Swap_Ack in the next cycle, with no wait and no COPY.
REQ-034 Requests arriving in non-IDLE states SHALL NOT be queued; a held i_Swap_Req on return to IDLE SHALL start another swap.
REQ-035 The row counter SHALL be YW bits wide, SHALL reset to 0 on each FILL/COPY entry, and SHALL terminate at HEIGHT-1 with no wrap.

Reset
REQ-036 On reset: all buffers cleared, front-select=0, state=IDLE, o_Swap_Ack=0, o_Err_Range=0, o_Busy=0.
REQ-037 On the cycle after reset, o_MAX7219_DataStream SHALL hold every element as {8'(d+1),8'h00}.
REQ-038 Reset during FILL, SWAP_WAIT or COPY SHALL abort the operation without emitting o_Swap_Ack.

Verification
REQ-039 Reset with default parameters -> every element [d][dr][dc] = {d+1,00}, e.g. [0][0][0]=16'h0100 and [7][4][3]=16'h0800; o_Pix_Ready=1.
REQ-040 Set (7,0), then swap request, then i_Frame_Done after 10 cycles -> stream unchanged before the swap; o_Swap_Ack 1 cycle; [0][0][0]=16'h0180 one cycle after the ack; o_Busy high for 40 COPY cycles.
REQ-041 Set (31,39), swap -> [7][4][3]=16'h0880; toggle (31,39), swap -> 16'h0800.
REQ-042 Set with y=40 -> o_Err_Range pulses once; buffers unchanged.
REQ-043 Fill 1 -> o_Pix_Ready low and o_Busy high for 40 cycles; after the swap all data bytes = 8'hFF; reset asserted mid-fill -> all data bytes 00 and o_Busy=0.
REQ-044 DOUBLE_BUFFER=0: set (0,8) -> [0][1][0]=16'h0101 one cycle after acceptance; swap request -> o_Swap_Ack in the next cycle with no i_Frame_Done.

Source files
------------

// File: rtl/max7219_framebuffer_if.sv
// Bus between a drawing client and the MAX7219 framebuffer: pixel/fill/swap
// requests, refresh handshake from the SPI driver, and the display stream.
interface max7219_framebuffer_if #(
    parameter int DISP_ROWS    = 5,
    parameter int DISP_COLUMNS = 4
);
    localparam int XW = $clog2(DISP_COLUMNS * 8);
    localparam int YW = $clog2(DISP_ROWS * 8);

    logic          i_Pix_Valid;
    logic          o_Pix_Ready;
    logic [XW-1:0] i_Pix_X;
    logic [YW-1:0] i_Pix_Y;
    logic [1:0]    i_Pix_Op;
    logic          i_Fill_Valid;
    logic          i_Fill_Value;
    logic          i_Swap_Req;
    logic          i_Frame_Done;
    logic          o_Swap_Ack;
    logic          o_Busy;
    logic          o_Err_Range;
    logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0] o_MAX7219_DataStream;

    modport master (
        output i_Pix_Valid, i_Pix_X, i_Pix_Y, i_Pix_Op,
        output i_Fill_Valid, i_Fill_Value, i_Swap_Req, i_Frame_Done,
        input  o_Pix_Ready, o_Swap_Ack, o_Busy, o_Err_Range, o_MAX7219_DataStream
    );

    modport slave (
        input  i_Pix_Valid, i_Pix_X, i_Pix_Y, i_Pix_Op,
        input  i_Fill_Valid, i_Fill_Value, i_Swap_Req, i_Frame_Done,
        output o_Pix_Ready, o_Swap_Ack, o_Busy, o_Err_Range, o_MAX7219_DataStream
    );
endinterface

// File: rtl/max7219_framebuffer.sv
// Pixel framebuffer for a chain of 8x8 MAX7219 matrices with optional double
// buffering; presents the front buffer as per-digit register words.
module max7219_framebuffer #(
    parameter int DISP_ROWS     = 5,
    parameter int DISP_COLUMNS  = 4,
    parameter int DOUBLE_BUFFER = 1
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst,
    max7219_framebuffer_if.slave        bus
);
    localparam int WIDTH  = DISP_COLUMNS * 8;
    localparam int HEIGHT = DISP_ROWS * 8;
    localparam int XW     = $clog2(WIDTH);
    localparam int YW     = $clog2(HEIGHT);
    localparam int NBUF   = (DOUBLE_BUFFER != 0) ? 2 : 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILL      = 2'd1,
        ST_SWAP_WAIT = 2'd2,
        ST_COPY      = 2'd3
    } state_t;

    state_t          state_r;
    logic [YW-1:0]   row_cnt_r;
    logic            fill_val_r;
    logic            front_sel_r;
    logic            swap_ack_r;
    logic            err_range_r;
    logic            busy_r;
    logic [WIDTH-1:0] mem_r [0:NBUF-1][0:HEIGHT-1];
    logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0] stream_r;

    logic            front_idx_s;
    logic            draw_idx_s;
    logic            pix_ready_s;
    logic            pix_in_range_s;
    logic            pix_write_s;
    logic            last_row_s;
    logic [YW-1:0]   pix_row_s;
    logic [WIDTH-1:0] pix_cur_s;
    logic [WIDTH-1:0] pix_mask_s;
    logic            wr_en_s;
    logic [YW-1:0]   wr_row_s;
    logic [WIDTH-1:0] wr_data_s;

    assign pix_ready_s    = (state_r == ST_IDLE) && !bus.i_Fill_Valid &&
                            !bus.i_Swap_Req && !i_Rst;
    assign pix_in_range_s = ({1'b0, bus.i_Pix_X} < (XW+1)'(WIDTH)) &&
                            ({1'b0, bus.i_Pix_Y} < (YW+1)'(HEIGHT));
    assign pix_write_s    = pix_ready_s && bus.i_Pix_Valid && pix_in_range_s &&
                            (bus.i_Pix_Op != 2'b11);
    // Clamp keeps the read index legal even while a bad command is on the bus
    assign pix_row_s      = pix_in_range_s ? bus.i_Pix_Y : {YW{1'b0}};
    assign pix_mask_s     = {{(WIDTH-1){1'b0}}, 1'b1} << bus.i_Pix_X;
    assign last_row_s     = (row_cnt_r == YW'(HEIGHT - 1));

    // Buffer selection: with a single buffer, draw and front alias one array
    always_comb begin
        if (DOUBLE_BUFFER != 0) begin
            front_idx_s = front_sel_r;
            draw_idx_s  = ~front_sel_r;
        end else begin
            front_idx_s = 1'b0;
            draw_idx_s  = 1'b0;
        end
    end

    assign pix_cur_s = mem_r[draw_idx_s][pix_row_s];

    // Draw-buffer row write: pixel read-modify-write, fill row, or copy row
    always_comb begin
        wr_en_s   = 1'b0;
        wr_row_s  = {YW{1'b0}};
        wr_data_s = {WIDTH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (pix_write_s) begin
                    wr_en_s  = 1'b1;
                    wr_row_s = pix_row_s;
                    case (bus.i_Pix_Op)
                        2'b00:   wr_data_s = pix_cur_s & ~pix_mask_s;
                        2'b01:   wr_data_s = pix_cur_s | pix_mask_s;
                        2'b10:   wr_data_s = pix_cur_s ^ pix_mask_s;
                        default: wr_data_s = pix_cur_s;
                    endcase
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            ST_FILL: begin
                wr_en_s   = 1'b1;
                wr_row_s  = row_cnt_r;
                wr_data_s = {WIDTH{fill_val_r}};
            end
            ST_COPY: begin
                wr_en_s   = 1'b1;
                wr_row_s  = row_cnt_r;
                wr_data_s = mem_r[front_idx_s][row_cnt_r];
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
    end

    // Pixel storage
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            for (int b = 0; b < NBUF; b++) begin
                for (int r = 0; r < HEIGHT; r++) begin
                    mem_r[b][r] <= {WIDTH{1'b0}};
                end
            end
        end else if (wr_en_s) begin
            mem_r[draw_idx_s][wr_row_s] <= wr_data_s;
        end
    end

    // Control FSM: fill, swap handshake with the refresh driver, and copy-back
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_r     <= ST_IDLE;
            row_cnt_r   <= {YW{1'b0}};
            fill_val_r  <= 1'b0;
            front_sel_r <= 1'b0;
            swap_ack_r  <= 1'b0;
            err_range_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            swap_ack_r  <= 1'b0;
            err_range_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.i_Fill_Valid) begin
                        fill_val_r <= bus.i_Fill_Value;
                        row_cnt_r  <= {YW{1'b0}};
                        state_r    <= ST_FILL;
                        busy_r     <= 1'b1;
                    end else if (bus.i_Swap_Req) begin
                        if (DOUBLE_BUFFER != 0) begin
                            state_r <= ST_SWAP_WAIT;
                            busy_r  <= 1'b1;
                        end else begin
                            swap_ack_r <= 1'b1;
                        end
                    end else if (bus.i_Pix_Valid && !pix_in_range_s) begin
                        err_range_r <= 1'b1;
                    end
                end
                ST_FILL, ST_COPY: begin
                    if (last_row_s) begin
                        row_cnt_r <= {YW{1'b0}};
                        state_r   <= ST_IDLE;
                        busy_r    <= 1'b0;
                    end else begin
                        row_cnt_r <= row_cnt_r + {{(YW-1){1'b0}}, 1'b1};
                    end
                end
                ST_SWAP_WAIT: begin
                    // Swap only at a refresh boundary so a frame is never torn
                    if (bus.i_Frame_Done) begin
                        front_sel_r <= ~front_sel_r;
                        swap_ack_r  <= 1'b1;
                        row_cnt_r   <= {YW{1'b0}};
                        state_r     <= ST_COPY;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Display stream: digit register address d+1 with the matching front byte
    always_ff @(posedge i_Clk) begin
        for (int d = 0; d < 8; d++) begin
            for (int dr = 0; dr < DISP_ROWS; dr++) begin
                for (int dc = 0; dc < DISP_COLUMNS; dc++) begin
                    if (i_Rst) begin
                        stream_r[d][dr][dc] <= {8'(d + 1), 8'h00};
                    end else begin
                        stream_r[d][dr][dc] <= {8'(d + 1),
                            mem_r[front_idx_s][YW'(dr * 8 + d)][dc * 8 +: 8]};
                    end
                end
            end
        end
    end

    assign bus.o_Pix_Ready          = pix_ready_s;
    assign bus.o_Swap_Ack           = swap_ack_r;
    assign bus.o_Busy               = busy_r;
    assign bus.o_Err_Range          = err_range_r;
    assign bus.o_MAX7219_DataStream = stream_r;

endmodule

// File: tb/tb_max7219_framebuffer.sv
// Directed bench for max7219_framebuffer: double-buffered default instance
// plus a single-buffer instance sharing clock and reset.
module tb_max7219_framebuffer;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    max7219_framebuffer_if #(.DISP_ROWS(5), .DISP_COLUMNS(4)) fb ();
    max7219_framebuffer_if #(.DISP_ROWS(5), .DISP_COLUMNS(4)) fb0 ();

    max7219_framebuffer #(.DISP_ROWS(5), .DISP_COLUMNS(4), .DOUBLE_BUFFER(1)) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (fb.slave)
    );

    max7219_framebuffer #(.DISP_ROWS(5), .DISP_COLUMNS(4), .DOUBLE_BUFFER(0)) dut0 (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (fb0.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix_cmd(input logic [4:0] x, input logic [5:0] y, input logic [1:0] op);
        fb.i_Pix_Valid = 1'b1;
        fb.i_Pix_X     = x;
        fb.i_Pix_Y     = y;
        fb.i_Pix_Op    = op;
        tick();
        fb.i_Pix_Valid = 1'b0;
        fb.i_Pix_Op    = 2'b11;
    endtask

    task automatic run_swap(input int fd_delay, output bit ok);
        ok = 1'b1;
        fb.i_Swap_Req = 1'b1;
        tick();
        fb.i_Swap_Req = 1'b0;
        repeat (fd_delay) tick();
        fb.i_Frame_Done = 1'b1;
        tick();
        fb.i_Frame_Done = 1'b0;
        if (fb.o_Swap_Ack !== 1'b1) ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!fb.o_Busy) break;
            tick();
        end
        if (fb.o_Busy !== 1'b0) ok = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if (fb.o_Pix_Ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready_in_reset: got %b want 0", fb.o_Pix_Ready);
        end
        rst = 1'b0;
        #1;
        bad = 0;
        for (int d = 0; d < 8; d++)
            for (int dr = 0; dr < 5; dr++)
                for (int dc = 0; dc < 4; dc++)
                    if (fb.o_MAX7219_DataStream[d][dr][dc] !== {8'(d + 1), 8'h00}) bad++;
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL reset_stream: %0d bad elements, want 0", bad);
        end
        tests_run++;
        if (fb.o_MAX7219_DataStream[0][0][0] !== 16'h0100) begin
            tests_failed++;
            $display("FAIL reset_elem_000: got %h want 0100", fb.o_MAX7219_DataStream[0][0][0]);
        end
        tests_run++;
        if (fb.o_MAX7219_DataStream[7][4][3] !== 16'h0800) begin
            tests_failed++;
            $display("FAIL reset_elem_743: got %h want 0800", fb.o_MAX7219_DataStream[7][4][3]);
        end
        tests_run++;
        if ({fb.o_Pix_Ready, fb.o_Busy, fb.o_Swap_Ack, fb.o_Err_Range} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset_flags: rdy/busy/ack/err got %b want 1000",
                     {fb.o_Pix_Ready, fb.o_Busy, fb.o_Swap_Ack, fb.o_Err_Range});
        end
        tests_run++;
        if ({fb0.o_Pix_Ready, fb0.o_Busy} !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_sb_flags: rdy/busy got %b want 10", {fb0.o_Pix_Ready, fb0.o_Busy});
        end
    endtask

    task automatic test_swap();
        int busy_cnt;
        pix_cmd(5'd7, 6'd0, 2'b01);
        tick();
        tests_run++;
        if (fb.o_MAX7219_DataStream[0][0][0] !== 16'h0100) begin
            tests_failed++;
            $display("FAIL swap_pre_stream: got %h want 0100", fb.o_MAX7219_DataStream[0][0][0]);
        end
        fb.i_Swap_Req = 1'b1;
        tick();
        fb.i_Swap_Req = 1'b0;
        tests_run++;
        if ({fb.o_Busy, fb.o_Swap_Ack} !== 2'b10) begin
            tests_failed++;
            $display("FAIL swap_wait_flags: busy/ack got %b want 10", {fb.o_Busy, fb.o_Swap_Ack});
        end
        repeat (10) tick();
        tests_run++;
        if ({fb.o_MAX7219_DataStream[0][0][0], fb.o_Swap_Ack} !== {16'h0100, 1'b0}) begin
            tests_failed++;
            $display("FAIL swap_wait_stream: got %h ack %b want 0100 ack 0",
                     fb.o_MAX7219_DataStream[0][0][0], fb.o_Swap_Ack);
        end
        fb.i_Frame_Done = 1'b1;
        tick();
        fb.i_Frame_Done = 1'b0;
        tests_run++;
        if ({fb.o_Swap_Ack, fb.o_MAX7219_DataStream[0][0][0]} !== {1'b1, 16'h0100}) begin
            tests_failed++;
            $display("FAIL swap_ack: ack %b stream %h want ack 1 stream 0100",
                     fb.o_Swap_Ack, fb.o_MAX7219_DataStream[0][0][0]);
        end
        busy_cnt = fb.o_Busy ? 1 : 0;
        tests_run++;
        if (fb.o_Pix_Ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL swap_copy_ready: got %b want 0", fb.o_Pix_Ready);
        end
        tick();
        tests_run++;
        if ({fb.o_Swap_Ack, fb.o_MAX7219_DataStream[0][0][0]} !== {1'b0, 16'h0180}) begin
            tests_failed++;
            $display("FAIL swap_post: ack %b stream %h want ack 0 stream 0180",
                     fb.o_Swap_Ack, fb.o_MAX7219_DataStream[0][0][0]);
        end
        for (int i = 0; i < 100; i++) begin
            if (!fb.o_Busy) break;
            busy_cnt++;
            tick();
        end
        tests_run++;
        if (busy_cnt !== 40) begin
            tests_failed++;
            $display("FAIL swap_copy_cycles: got %0d want 40", busy_cnt);
        end
    endtask

    task automatic test_corner();
        bit ok;
        pix_cmd(5'd31, 6'd39, 2'b01);
        run_swap(3, ok);
        tests_run++;
        if ({ok, fb.o_MAX7219_DataStream[7][4][3], fb.o_MAX7219_DataStream[0][0][0]}
                !== {1'b1, 16'h0880, 16'h0180}) begin
            tests_failed++;
            $display("FAIL corner_set: ok %b e743 %h e000 %h want 1 0880 0180",
                     ok, fb.o_MAX7219_DataStream[7][4][3], fb.o_MAX7219_DataStream[0][0][0]);
        end
        pix_cmd(5'd31, 6'd39, 2'b10);
        run_swap(0, ok);
        tests_run++;
        if ({ok, fb.o_MAX7219_DataStream[7][4][3]} !== {1'b1, 16'h0800}) begin
            tests_failed++;
            $display("FAIL corner_toggle: ok %b e743 %h want 1 0800",
                     ok, fb.o_MAX7219_DataStream[7][4][3]);
        end
    endtask

    task automatic test_err_range();
        bit ok;
        int bad;
        logic [15:0] exp_v;
        pix_cmd(5'd5, 6'd40, 2'b01);
        tests_run++;
        if (fb.o_Err_Range !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_pulse: got %b want 1", fb.o_Err_Range);
        end
        tick();
        tests_run++;
        if (fb.o_Err_Range !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_pulse_end: got %b want 0", fb.o_Err_Range);
        end
        pix_cmd(5'd0, 6'd0, 2'b11);
        tests_run++;
        if (fb.o_Err_Range !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_noop_inrange: got %b want 0", fb.o_Err_Range);
        end
        run_swap(2, ok);
        bad = 0;
        for (int d = 0; d < 8; d++)
            for (int dr = 0; dr < 5; dr++)
                for (int dc = 0; dc < 4; dc++) begin
                    exp_v = (d == 0 && dr == 0 && dc == 0) ? 16'h0180 : {8'(d + 1), 8'h00};
                    if (fb.o_MAX7219_DataStream[d][dr][dc] !== exp_v) bad++;
                end
        tests_run++;
        if ({ok, bad} !== {1'b1, 32'd0}) begin
            tests_failed++;
            $display("FAIL err_buffers: ok %b bad %0d want ok 1 bad 0", ok, bad);
        end
    endtask

    task automatic test_fill();
        bit ok;
        int busy_cnt;
        int low_cnt;
        int bad;
        fb.i_Fill_Valid = 1'b1;
        fb.i_Fill_Value = 1'b1;
        #1;
        tests_run++;
        if (fb.o_Pix_Ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_req_ready: got %b want 0", fb.o_Pix_Ready);
        end
        tick();
        fb.i_Fill_Valid = 1'b0;
        busy_cnt = 0;
        low_cnt  = 0;
        for (int i = 0; i < 100; i++) begin
            if (!fb.o_Busy) break;
            busy_cnt++;
            if (!fb.o_Pix_Ready) low_cnt++;
            tick();
        end
        tests_run++;
        if ({busy_cnt, low_cnt} !== {32'd40, 32'd40}) begin
            tests_failed++;
            $display("FAIL fill_cycles: busy %0d ready_low %0d want 40 40", busy_cnt, low_cnt);
        end
        run_swap(1, ok);
        bad = 0;
        for (int d = 0; d < 8; d++)
            for (int dr = 0; dr < 5; dr++)
                for (int dc = 0; dc < 4; dc++)
                    if (fb.o_MAX7219_DataStream[d][dr][dc] !== {8'(d + 1), 8'hFF}) bad++;
        tests_run++;
        if ({ok, bad} !== {1'b1, 32'd0}) begin
            tests_failed++;
            $display("FAIL fill_ones: ok %b bad %0d want ok 1 bad 0", ok, bad);
        end
        fb.i_Fill_Valid = 1'b1;
        tick();
        fb.i_Fill_Valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        bad = 0;
        for (int d = 0; d < 8; d++)
            for (int dr = 0; dr < 5; dr++)
                for (int dc = 0; dc < 4; dc++)
                    if (fb.o_MAX7219_DataStream[d][dr][dc] !== {8'(d + 1), 8'h00}) bad++;
        tests_run++;
        if ({fb.o_Busy, bad} !== {1'b0, 32'd0}) begin
            tests_failed++;
            $display("FAIL fill_reset_abort: busy %b bad %0d want busy 0 bad 0", fb.o_Busy, bad);
        end
    endtask

    task automatic test_reset_abort();
        int ack_cnt;
        fb.i_Swap_Req = 1'b1;
        tick();
        fb.i_Swap_Req   = 1'b0;
        rst             = 1'b1;
        fb.i_Frame_Done = 1'b1;
        tick();
        rst             = 1'b0;
        fb.i_Frame_Done = 1'b0;
        ack_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (fb.o_Swap_Ack) ack_cnt++;
            if (i == 1) fb.i_Frame_Done = 1'b1;
            tick();
            fb.i_Frame_Done = 1'b0;
        end
        tests_run++;
        if ({ack_cnt, fb.o_Busy} !== {32'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_abort_swap: acks %0d busy %b want 0 0", ack_cnt, fb.o_Busy);
        end
    endtask

    task automatic test_back_to_back();
        fb.i_Swap_Req   = 1'b1;
        fb.i_Frame_Done = 1'b1;
        tick();
        fb.i_Frame_Done = 1'b0;
        tick();
        tests_run++;
        if ({fb.o_Swap_Ack, fb.o_Busy} !== 2'b01) begin
            tests_failed++;
            $display("FAIL b2b_entry_done_ignored: ack/busy got %b want 01", {fb.o_Swap_Ack, fb.o_Busy});
        end
        fb.i_Frame_Done = 1'b1;
        tick();
        fb.i_Frame_Done = 1'b0;
        tests_run++;
        if (fb.o_Swap_Ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ack1: got %b want 1", fb.o_Swap_Ack);
        end
        for (int i = 0; i < 100; i++) begin
            if (!fb.o_Busy) break;
            tick();
        end
        tests_run++;
        if ({fb.o_Busy, fb.o_Pix_Ready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL b2b_idle_gap: busy/ready got %b want 00", {fb.o_Busy, fb.o_Pix_Ready});
        end
        tick();
        fb.i_Swap_Req = 1'b0;
        tests_run++;
        if (fb.o_Busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_restart: busy got %b want 1", fb.o_Busy);
        end
        fb.i_Frame_Done = 1'b1;
        tick();
        fb.i_Frame_Done = 1'b0;
        tests_run++;
        if (fb.o_Swap_Ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ack2: got %b want 1", fb.o_Swap_Ack);
        end
        for (int i = 0; i < 100; i++) begin
            if (!fb.o_Busy) break;
            tick();
        end
        tick();
        tests_run++;
        if ({fb.o_Busy, fb.o_Pix_Ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL b2b_done: busy/ready got %b want 01", {fb.o_Busy, fb.o_Pix_Ready});
        end
    endtask

    task automatic test_single_buffer();
        fb0.i_Pix_Valid = 1'b1;
        fb0.i_Pix_X     = 5'd0;
        fb0.i_Pix_Y     = 6'd8;
        fb0.i_Pix_Op    = 2'b01;
        tick();
        fb0.i_Pix_Valid = 1'b0;
        fb0.i_Pix_Op    = 2'b11;
        tests_run++;
        if (fb0.o_MAX7219_DataStream[0][1][0] !== 16'h0100) begin
            tests_failed++;
            $display("FAIL sb_latency: got %h want 0100", fb0.o_MAX7219_DataStream[0][1][0]);
        end
        tick();
        tests_run++;
        if (fb0.o_MAX7219_DataStream[0][1][0] !== 16'h0101) begin
            tests_failed++;
            $display("FAIL sb_pixel: got %h want 0101", fb0.o_MAX7219_DataStream[0][1][0]);
        end
        fb0.i_Swap_Req = 1'b1;
        tick();
        fb0.i_Swap_Req = 1'b0;
        tests_run++;
        if ({fb0.o_Swap_Ack, fb0.o_Busy} !== 2'b10) begin
            tests_failed++;
            $display("FAIL sb_swap_ack: ack/busy got %b want 10", {fb0.o_Swap_Ack, fb0.o_Busy});
        end
        tick();
        tests_run++;
        if ({fb0.o_Swap_Ack, fb0.o_MAX7219_DataStream[0][1][0]} !== {1'b0, 16'h0101}) begin
            tests_failed++;
            $display("FAIL sb_after_swap: ack %b stream %h want 0 0101",
                     fb0.o_Swap_Ack, fb0.o_MAX7219_DataStream[0][1][0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before timeout");
        $fatal(1);
    end

    initial begin
        clk          = 1'b0;
        rst          = 1'b1;
        tests_run    = 0;
        tests_failed = 0;
        fb.i_Pix_Valid   = 1'b0;
        fb.i_Pix_X       = 5'd0;
        fb.i_Pix_Y       = 6'd0;
        fb.i_Pix_Op      = 2'b11;
        fb.i_Fill_Valid  = 1'b0;
        fb.i_Fill_Value  = 1'b0;
        fb.i_Swap_Req    = 1'b0;
        fb.i_Frame_Done  = 1'b0;
        fb0.i_Pix_Valid  = 1'b0;
        fb0.i_Pix_X      = 5'd0;
        fb0.i_Pix_Y      = 6'd0;
        fb0.i_Pix_Op     = 2'b11;
        fb0.i_Fill_Valid = 1'b0;
        fb0.i_Fill_Value = 1'b0;
        fb0.i_Swap_Req   = 1'b0;
        fb0.i_Frame_Done = 1'b0;

        test_reset();
        test_swap();
        test_corner();
        test_err_range();
        test_fill();
        test_reset_abort();
        test_back_to_back();
        test_single_buffer();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
